channel_capture: RTL and testbench

- Producer side of the trace display path.
- Samples one asynchronous logic channel at a programmable rate and waits for a configurable trigger.
- Fills a DATA_SIZE-bit capture buffer, then presents it on a stable, frame-synchronised output bus to the pixel-status renderer.
- Double-buffered: the display-facing bus changes only on a frame_sync pulse, so a frame never shows a mix of two captures.

---
 rtl/channel_capture.sv | 152 +++++++++++++++
 tb/tb_channel_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_capture.sv
// channel_capture: samples one asynchronous logic channel at a programmable
// rate, waits for a trigger and fills a DATA_SIZE-sample buffer. The buffer is
// then handed to the display bus on a frame_sync pulse, so a frame always shows
// one complete capture.
module channel_capture #(
  parameter int DATA_SIZE = 256,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_in,
  input  logic [DIV_WIDTH-1:0] sample_div,
  input  logic [1:0]           trig_mode,
  input  logic                 arm,
  input  logic                 continuous,
  input  logic                 frame_sync,
  output logic [DATA_SIZE-1:0] data,
  output logic                 data_valid,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_SIZE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [1:0] TRIG_FREE    = 2'b00;
  localparam logic [1:0] TRIG_RISING  = 2'b01;
  localparam logic [1:0] TRIG_FALLING = 2'b10;

  state_t               state;
  logic                 s_meta;
  logic                 s_sync;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] pre_cnt;
  logic                 prev;
  logic                 prev_valid;
  logic [IDX_W-1:0]     idx;
  logic [DATA_SIZE-1:0] cap_buf;
  logic                 strobe;
  logic                 trig_hit;

  // Two-flop synchroniser: everything downstream looks at s_sync only.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples the values
    // that existed before the edge; with = the second stage would see the
    // first stage's new value and the synchroniser would collapse to one flop.
    if (rst) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
    end else begin
      s_meta <= sig_in;
      s_sync <= s_meta;
    end
  end

  // Sample strobe: fires when the prescale counter reaches the latched divider.
  assign strobe = (pre_cnt == div_q);

  // Trigger decision for the current strobe; edge modes need a valid prev.
  always_comb begin
    // NOTE: default first so every path assigns trig_hit and no latch forms.
    trig_hit = 1'b0;
    case (trig_mode)
      TRIG_FREE:    trig_hit = 1'b1;
      TRIG_RISING:  trig_hit = prev_valid && !prev && s_sync;
      TRIG_FALLING: trig_hit = prev_valid && prev && !s_sync;
      default:      trig_hit = prev_valid && (prev != s_sync);
    endcase
  end

  // Capture FSM with registered display bus and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_q      <= '0;
      pre_cnt    <= '0;
      prev       <= 1'b0;
      prev_valid <= 1'b0;
      idx        <= '0;
      // NOTE: the capture buffer is a plain register vector, not a RAM, so it
      // can be cleared here; an aborted capture then leaves nothing stale.
      cap_buf    <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // frame_sync is meaningless here; only arm is looked at.
          if (arm) begin
            state      <= WAIT_TRIG;
            busy       <= 1'b1;
            div_q      <= sample_div;
            pre_cnt    <= '0;
            prev_valid <= 1'b0;
          end
        end

        WAIT_TRIG: begin
          pre_cnt <= strobe ? '0 : pre_cnt + 1'b1;
          if (strobe) begin
            prev       <= s_sync;
            prev_valid <= 1'b1;
            if (trig_hit) begin
              cap_buf[0] <= s_sync;
              idx        <= IDX_W'(1);
              state      <= CAPTURE;
            end
          end
        end

        CAPTURE: begin
          pre_cnt <= strobe ? '0 : pre_cnt + 1'b1;
          if (strobe) begin
            cap_buf[idx] <= s_sync;
            idx          <= idx + 1'b1;
            // The last write ends the pass; idx wrapping to 0 is never used.
            if (idx == IDX_W'(DATA_SIZE - 1)) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          if (frame_sync) begin
            data       <= cap_buf;
            data_valid <= 1'b1;
            if (continuous) begin
              state      <= WAIT_TRIG;
              pre_cnt    <= '0;
              prev_valid <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_capture.sv
// Bench for channel_capture with DATA_SIZE=32. Expected captures are pushed to
// a scoreboard queue when their stimulus is set up and popped when a
// frame_sync transfer is expected to present them on the data bus.
module tb_channel_capture;

  localparam int DATA_SIZE = 32;
  localparam int DIV_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sig_drv = 1'b0;
  logic                 sq_en = 1'b0;
  logic                 sq_val = 1'b0;
  wire                  sig_in;
  logic [DIV_WIDTH-1:0] sample_div = '0;
  logic [1:0]           trig_mode = 2'b00;
  logic                 arm = 1'b0;
  logic                 continuous = 1'b0;
  logic                 frame_sync = 1'b0;
  logic [DATA_SIZE-1:0] data;
  logic                 data_valid;
  logic                 busy;

  int                   n_tests = 0;
  int                   n_fail = 0;
  logic [31:0]          exp_q[$];
  logic [31:0]          shown = '0;

  assign sig_in = sq_en ? sq_val : sig_drv;

  channel_capture #(
    .DATA_SIZE(DATA_SIZE),
    .DIV_WIDTH(DIV_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .sample_div (sample_div),
    .trig_mode  (trig_mode),
    .arm        (arm),
    .continuous (continuous),
    .frame_sync (frame_sync),
    .data       (data),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Square wave of 10 clocks high / 10 clocks low (period 20 samples at div 0).
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sq_en) begin
        if (cnt == 9) begin
          cnt = 0;
          sq_val = ~sq_val;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        sq_val = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
  endtask

  task automatic check_transfer(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got a transfer, expected an entry in the scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, data, e);
      check({tag, "_valid"}, 32'(data_valid), 32'd1);
      shown = e;
    end
  endtask

  // Free-run capture at div 0: bit j of pat is the value the capture stores as
  // sample j, given the two-flop synchroniser ahead of the sampler.
  task automatic drive_capture(input logic [31:0] pat, input logic with_fs);
    trig_mode  = 2'b00;
    sample_div = '0;
    sig_drv    = pat[0];
    tick(1);
    arm        = 1'b1;
    frame_sync = with_fs;
    sig_drv    = pat[1];
    exp_q.push_back(pat);
    tick(1);
    arm        = 1'b0;
    frame_sync = 1'b0;
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_data_hold", data, shown);
    for (int j = 2; j < 32; j++) begin
      sig_drv = pat[j];
      tick(1);
    end
  endtask

  initial begin
    // 1. Reset with sig_in toggling, then idle without arm.
    #1;
    for (int i = 0; i < 3; i++) begin
      sig_drv = ~sig_drv;
      tick(1);
    end
    rst = 1'b0;
    check("rst_data", data, 32'h0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    pulse_fs();
    tick(5);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_data", data, 32'h0);

    // 2. Free-run, div 0, with frame_sync coinciding with arm in IDLE.
    drive_capture(32'hA5A5_0F0F, 1'b1);
    tick(9);
    pulse_fs();
    check_transfer("t2");
    check("t2_busy", 32'(busy), 32'd0);

    // 3. Rising trigger, div 3; a later sample_div change must not matter.
    sig_drv    = 1'b0;
    trig_mode  = 2'b01;
    sample_div = 16'd3;
    tick(4);
    arm = 1'b1;
    exp_q.push_back(32'h0000_FFFF);
    tick(1);
    arm        = 1'b0;
    sample_div = 16'd0;
    tick(49);
    sig_drv = 1'b1;
    tick(64);
    sig_drv = 1'b0;
    tick(80);
    check("t3_busy_done", 32'(busy), 32'd1);
    pulse_fs();
    check_transfer("t3");

    // 4. Tear-free swap: A all ones shown, then B all zeros.
    sig_drv    = 1'b1;
    trig_mode  = 2'b00;
    sample_div = '0;
    tick(3);
    arm = 1'b1;
    exp_q.push_back(32'hFFFF_FFFF);
    tick(1);
    arm = 1'b0;
    tick(40);
    pulse_fs();
    check_transfer("t4_a");
    sig_drv = 1'b0;
    tick(3);
    arm = 1'b1;
    exp_q.push_back(32'h0000_0000);
    tick(1);
    arm = 1'b0;
    tick(13);
    pulse_fs();
    check("t4_mid_hold", data, shown);
    tick(17);
    pulse_fs();
    check("t4_last_hold", data, shown);
    check("t4_last_busy", 32'(busy), 32'd1);
    tick(1);
    check("t4_after_hold", data, shown);
    pulse_fs();
    check_transfer("t4_b");

    // 5. Continuous, falling trigger, square wave of period 20 samples.
    trig_mode  = 2'b10;
    sample_div = '0;
    continuous = 1'b1;
    sq_en      = 1'b1;
    tick(5);
    arm = 1'b1;
    exp_q.push_back(32'hC00F_FC00);
    tick(1);
    arm = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(35);
      check($sformatf("t5_gap_busy%0d", k), 32'(busy), 32'd1);
      tick(34);
      if (k == 2) continuous = 1'b0;
      pulse_fs();
      check_transfer($sformatf("t5_xfer%0d", k));
      check($sformatf("t5_busy%0d", k), 32'(busy), (k < 2) ? 32'd1 : 32'd0);
      if (k < 2) exp_q.push_back(32'hC00F_FC00);
    end
    sq_en = 1'b0;

    // 6. Reset after 10 samples aborts; a fresh capture starts at sample 0.
    sig_drv   = 1'b1;
    trig_mode = 2'b00;
    tick(3);
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    shown = '0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_data", data, 32'h0);
    check("t6_valid", 32'(data_valid), 32'd0);
    drive_capture(32'h1234_5678, 1'b0);
    tick(5);
    pulse_fs();
    check_transfer("t6");
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
